aq_sensor_filter: RTL and testbench



---
 rtl/aq_pkg.sv | 14 +
 rtl/aq_window_avg.sv | 74 +++++++
 rtl/aq_sensor_filter.sv | 140 ++++++++++++++
 tb/tb_aq_sensor_filter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/aq_pkg.sv
// Constants and FSM encoding shared by the air-quality filter and the
// threshold monitor bench, so the neutral reading stays consistent.
package aq_pkg;

    localparam int AQ_DATA_W = 8;
    localparam logic [AQ_DATA_W-1:0] AQ_SAFE_DEFAULT = 8'd50;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_FAULT  = 2'd2
    } aq_state_e;

endpackage

// File: rtl/aq_window_avg.sv
// Circular sample window with a running sum; avg is the floor of the mean.
// While filling, entries are only added, so stale buffer contents are never read.
module aq_window_avg
    import aq_pkg::*;
#(
    parameter int LOG2_WIN = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 clear,
    input  logic [AQ_DATA_W-1:0] data,
    output logic [AQ_DATA_W-1:0] avg,
    output logic                 full
);

    localparam int WIN   = 1 << LOG2_WIN;
    localparam int SUM_W = AQ_DATA_W + LOG2_WIN;

    logic [AQ_DATA_W-1:0] win_buf_q [WIN];
    logic [LOG2_WIN-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LOG2_WIN:0]    fill_q, fill_d;
    logic [SUM_W-1:0]     sum_q, sum_d;
    logic [LOG2_WIN-1:0]  wr_idx;

    assign full = (fill_q == (LOG2_WIN+1)'(WIN));
    assign avg  = sum_q[SUM_W-1:LOG2_WIN];

    always_comb begin
        sum_d    = sum_q;
        fill_d   = fill_q;
        wr_ptr_d = wr_ptr_q;
        wr_idx   = wr_ptr_q;
        if (clear) begin
            // A push alongside clear becomes the first entry of a fresh window.
            wr_idx   = '0;
            sum_d    = '0;
            fill_d   = '0;
            wr_ptr_d = '0;
            if (push) begin
                sum_d    = SUM_W'(data);
                fill_d   = (LOG2_WIN+1)'(1);
                wr_ptr_d = LOG2_WIN'(1);
            end
        end else if (push) begin
            if (full) begin
                sum_d = sum_q - SUM_W'(win_buf_q[wr_ptr_q]) + SUM_W'(data);
            end else begin
                sum_d  = sum_q + SUM_W'(data);
                fill_d = fill_q + 1'b1;
            end
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q    <= '0;
            fill_q   <= '0;
            wr_ptr_q <= '0;
        end else begin
            sum_q    <= sum_d;
            fill_q   <= fill_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            win_buf_q[wr_idx] <= data;
        end
    end

endmodule

// File: rtl/aq_sensor_filter.sv
// Sensor conditioning: spike rejection, moving average and silent-sensor fault.
// adc_valid/adc_ready: a sample transfers on any clock edge where both are high.
module aq_sensor_filter
    import aq_pkg::*;
#(
    parameter int                   LOG2_WIN       = 2,
    parameter int                   SPIKE_DELTA    = 40,
    parameter int                   MAX_REJECT     = 3,
    parameter int                   TIMEOUT_CYCLES = 1000,
    parameter logic [AQ_DATA_W-1:0] SAFE_AQ        = AQ_SAFE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adc_valid,
    input  logic [AQ_DATA_W-1:0] adc_data,
    output logic                 adc_ready,
    output logic [AQ_DATA_W-1:0] air_quality,
    output logic                 aq_valid,
    output logic                 sensor_fault
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int REJ_W = (MAX_REJECT < 1) ? 1 : $clog2(MAX_REJECT + 1);

    aq_state_e            state_q, state_d;
    logic                 ready_q;
    logic [AQ_DATA_W-1:0] aq_q, aq_d;
    logic                 aqv_q, aqv_d;
    logic                 pub_q, pub_d;
    logic                 fault_pub_q, fault_pub_d;
    logic [REJ_W-1:0]     rej_q, rej_d;
    logic [TO_W-1:0]      to_q, to_d;

    logic                 hs, accept, run_mode, win_push, win_clear, win_full;
    logic [AQ_DATA_W-1:0] win_avg;
    logic [AQ_DATA_W:0]   diff;

    aq_window_avg #(.LOG2_WIN(LOG2_WIN)) u_win (
        .clk   (clk),
        .rst   (rst),
        .push  (win_push),
        .clear (win_clear),
        .data  (adc_data),
        .avg   (win_avg),
        .full  (win_full)
    );

    assign hs           = adc_valid & ready_q;
    assign adc_ready    = ready_q;
    assign air_quality  = aq_q;
    assign aq_valid     = aqv_q;
    assign sensor_fault = (state_q == ST_FAULT);

    // The cycle after the window fills is already RUN behaviour; state catches up here.
    assign run_mode = (state_q == ST_RUN) || ((state_q == ST_WARMUP) && win_full);

    always_comb begin
        if ({1'b0, adc_data} >= {1'b0, aq_q}) diff = {1'b0, adc_data} - {1'b0, aq_q};
        else                                  diff = {1'b0, aq_q} - {1'b0, adc_data};
        accept = (diff <= (AQ_DATA_W+1)'(SPIKE_DELTA)) || (rej_q == REJ_W'(MAX_REJECT));
    end

    always_comb begin
        state_d     = state_q;
        rej_d       = rej_q;
        pub_d       = 1'b0;
        fault_pub_d = 1'b0;
        win_push    = 1'b0;
        win_clear   = 1'b0;
        aq_d        = aq_q;
        aqv_d       = 1'b0;

        if (hs)                               to_d = '0;
        else if (to_q == TO_W'(TIMEOUT_CYCLES)) to_d = to_q;
        else                                  to_d = to_q + 1'b1;

        case (state_q)
            ST_FAULT: begin
                if (hs) begin
                    win_clear = 1'b1;
                    win_push  = 1'b1;
                    rej_d     = '0;
                    state_d   = ST_WARMUP;
                end
            end
            default: begin
                if (run_mode) begin
                    state_d = ST_RUN;
                    if (hs) begin
                        if (accept) begin
                            win_push = 1'b1;
                            rej_d    = '0;
                            pub_d    = 1'b1;
                        end else begin
                            rej_d = rej_q + 1'b1;
                        end
                    end
                end else begin
                    win_push = hs;
                end
                // A handshake on the expiry edge keeps the sensor alive.
                if (!hs && (to_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
                    state_d     = ST_FAULT;
                    fault_pub_d = 1'b1;
                end
            end
        endcase

        if (fault_pub_q) begin
            aq_d  = SAFE_AQ;
            aqv_d = 1'b1;
        end else if (pub_q || ((state_q == ST_WARMUP) && win_full)) begin
            aq_d  = win_avg;
            aqv_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_WARMUP;
            ready_q     <= 1'b0;
            aq_q        <= SAFE_AQ;
            aqv_q       <= 1'b0;
            pub_q       <= 1'b0;
            fault_pub_q <= 1'b0;
            rej_q       <= '0;
            to_q        <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= 1'b1;
            aq_q        <= aq_d;
            aqv_q       <= aqv_d;
            pub_q       <= pub_d;
            fault_pub_q <= fault_pub_d;
            rej_q       <= rej_d;
            to_q        <= to_d;
        end
    end

endmodule

// File: tb/tb_aq_sensor_filter.sv
// Directed bench for aq_sensor_filter: a per-cycle vector table plus
// hand-written timeout sequences.
module tb_aq_sensor_filter;
    import aq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       adc_valid = 1'b0;
    logic [7:0] adc_data = 8'd0;
    logic       adc_ready;
    logic [7:0] air_quality;
    logic       aq_valid;
    logic       sensor_fault;

    aq_sensor_filter #(
        .LOG2_WIN       (2),
        .SPIKE_DELTA    (40),
        .MAX_REJECT     (3),
        .TIMEOUT_CYCLES (1000),
        .SAFE_AQ        (8'd50)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .adc_valid    (adc_valid),
        .adc_data     (adc_data),
        .adc_ready    (adc_ready),
        .air_quality  (air_quality),
        .aq_valid     (aq_valid),
        .sensor_fault (sensor_fault)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic [7:0] aq;
        logic       av;
        logic       f;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic void add(input logic r, input logic v, input logic [7:0] d,
                                input logic [7:0] aq, input logic av, input logic f,
                                input logic rdy);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.aq = aq; t.av = av; t.f = f; t.rdy = rdy;
        vecs.push_back(t);
    endfunction

    // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        rst       = r;
        adc_valid = v;
        adc_data  = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0);
    endtask

    task automatic check(input string name, input logic [7:0] eaq, input logic eav,
                         input logic ef, input logic erdy);
        n_vec++;
        if (air_quality !== eaq || aq_valid !== eav || sensor_fault !== ef || adc_ready !== erdy) begin
            n_miss++;
            $display("FAIL %s: got aq=%0d aq_valid=%0b fault=%0b ready=%0b, want aq=%0d aq_valid=%0b fault=%0b ready=%0b",
                     name, air_quality, aq_valid, sensor_fault, adc_ready, eaq, eav, ef, erdy);
        end
    endtask

    initial begin
        // Warm-up with 20s, spike rejection and forced acceptance.
        add(1, 0, 0,   50, 0, 0, 0);
        add(0, 0, 0,   50, 0, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 1, 20, 50, 0, 0, 1);
        add(0, 0, 0,   20, 1, 0, 1);
        add(0, 0, 0,   20, 0, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 1, 200, 20, 0, 0, 1);
        add(0, 1, 200, 20, 0, 0, 1);
        add(0, 0, 0,   65, 1, 0, 1);
        add(0, 0, 0,   65, 0, 0, 1);
        // SPIKE_DELTA boundary, then lagging compare against the new average.
        add(1, 0, 0,   50, 0, 0, 0);
        add(0, 0, 0,   50, 0, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 1, 20, 50, 0, 0, 1);
        add(0, 0, 0,   20, 1, 0, 1);
        add(0, 1, 60,  20, 0, 0, 1);
        add(0, 0, 0,   30, 1, 0, 1);
        add(0, 1, 61,  30, 0, 0, 1);
        add(0, 0, 0,   40, 1, 0, 1);
        add(0, 0, 0,   40, 0, 0, 1);
        // Reset in the middle of a partially filled window.
        add(1, 0, 0,   50, 0, 0, 0);
        add(0, 0, 0,   50, 0, 0, 1);
        add(0, 1, 100, 50, 0, 0, 1);
        add(0, 1, 100, 50, 0, 0, 1);
        add(1, 0, 0,   50, 0, 0, 0);
        add(0, 0, 0,   50, 0, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 1, 100, 50, 0, 0, 1);
        add(0, 0, 0,   100, 1, 0, 1);
        add(0, 0, 0,   100, 0, 0, 1);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].v, vecs[i].d);
            check($sformatf("vec%0d", i), vecs[i].aq, vecs[i].av, vecs[i].f, vecs[i].rdy);
        end

        // Silent sensor: fault after 1000 idle edges, recovery through a fresh warm-up.
        step(1, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'd20);
        idle(1);
        check("to_publish", 20, 1, 0, 1);
        idle(998);
        check("to_999", 20, 0, 0, 1);
        idle(1);
        check("to_1000_fault", 20, 0, 1, 1);
        idle(1);
        check("fault_safe_aq", 50, 1, 1, 1);
        idle(1);
        check("fault_hold", 50, 0, 1, 1);
        step(0, 1, 8'd120);
        check("fault_recover", 50, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 8'd120);
        check("rewarm_fill", 50, 0, 0, 1);
        idle(1);
        check("rewarm_publish", 120, 1, 0, 1);

        // Handshake on the very edge the timeout would expire.
        step(1, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'd20);
        idle(999);
        check("edge_pre", 20, 0, 0, 1);
        step(0, 1, 8'd20);
        check("edge_hs_no_fault", 20, 0, 0, 1);
        idle(1);
        check("edge_hs_publish", 20, 1, 0, 1);
        idle(5);
        check("edge_after", 20, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
